// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the synchronous instruction
// memory address, tracks the one-cycle read latency and hands each returned
// word to decode tagged with its PC. A misaligned redirect halts the stage
// until reset.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instruction,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_target_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o,
  output logic        fault_o,
  output logic [31:0] fault_pc_o,
  output logic [31:0] fetch_count_o
);

  typedef enum logic {RUN, HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic        inflight_valid_q, inflight_valid_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic        misaligned;

  assign misaligned = (redirect_target_i[1:0] != 2'b00);

  // State register: every flop returns to its reset value as soon as rst_n drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= RUN;
      pc_q             <= RESET_PC;
      inflight_pc_q    <= RESET_PC;
      inflight_valid_q <= 1'b0;
      fault_q          <= 1'b0;
      fault_pc_q       <= 32'h0;
      fetch_count_q    <= 32'h0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      inflight_pc_q    <= inflight_pc_d;
      inflight_valid_q <= inflight_valid_d;
      fault_q          <= fault_d;
      fault_pc_q       <= fault_pc_d;
      fetch_count_q    <= fetch_count_d;
    end
  end

  // Next-state logic: redirect beats stall, a misaligned redirect beats everything.
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    inflight_pc_d    = inflight_pc_q;
    inflight_valid_d = inflight_valid_q;
    fault_d          = fault_q;
    fault_pc_d       = fault_pc_q;
    fetch_count_d    = fetch_count_q;
    if (state_q == RUN) begin
      if (redirect_i && misaligned) begin
        state_d          = HALT;
        fault_d          = 1'b1;
        fault_pc_d       = redirect_target_i;
        inflight_valid_d = 1'b0;
      end else if (redirect_i) begin
        // The word already requested belongs to the wrong path: drop it.
        pc_d             = redirect_target_i;
        inflight_valid_d = 1'b0;
      end else if (!stall_i) begin
        if (inflight_valid_q) begin
          fetch_count_d = fetch_count_q + 32'd1;
        end
        inflight_pc_d    = pc_q;
        inflight_valid_d = 1'b1;
        pc_d             = pc_q + 32'd4;
      end
    end
  end

  // While stalled the memory re-reads the presented word so its data stays put.
  always_comb begin
    imem_addr = pc_q;
    if (state_q == RUN && stall_i && !redirect_i) begin
      imem_addr = inflight_pc_q;
    end
  end

  assign valid_o       = inflight_valid_q && (state_q == RUN);
  assign instr_o       = valid_o ? imem_instruction : NOP_WORD;
  assign pc_o          = inflight_pc_q;
  assign pc_plus4_o    = inflight_pc_q + 32'd4;
  assign fault_o       = fault_q;
  assign fault_pc_o    = fault_pc_q;
  assign fetch_count_o = fetch_count_q;

endmodule
